// File: rtl/router_drain_arb.sv
// Drains whole packets from three router output FIFOs onto one byte stream,
// round-robin between packets, with a 2-entry output buffer and mid-packet timeout.
module router_drain_arb #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] dout_0,
    input  logic [7:0] dout_1,
    input  logic [7:0] dout_2,
    output logic       rd_en_0,
    output logic       rd_en_1,
    output logic       rd_en_2,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sop,
    output logic       m_eop,
    output logic [1:0] m_port,
    output logic       timeout_err
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] HDR      = 2'd1;
    localparam logic [1:0] HDR_WAIT = 2'd2;
    localparam logic [1:0] BODY     = 2'd3;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_reg, state_next;
    logic [1:0]    grant_reg, grant_next;
    logic [1:0]    rr_ptr_reg, rr_ptr_next;
    logic [6:0]    remaining_reg, remaining_next;
    logic [CW-1:0] idle_cnt_reg, idle_cnt_next;
    logic          timeout_err_reg, timeout_err_next;
    logic          inflight_reg, inflight_sop_reg, inflight_eop_reg;

    logic [7:0] fifo_data [2];
    logic [1:0] fifo_port [2];
    logic [1:0] fifo_sop, fifo_eop;
    logic       wr_ptr_reg, rd_ptr_reg;
    logic [1:0] count_reg;

    logic [2:0] vld_vec;
    logic [7:0] dout_arr [3];
    logic       vld_g;
    logic [7:0] dout_g;
    logic       rd, enq, deq, space, found;
    logic [1:0] pick;
    logic [2:0] occ_proj;
    logic [2:0] rd_en_vec;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    assign vld_vec     = {vld_out_2, vld_out_1, vld_out_0};
    assign dout_arr[0] = dout_0;
    assign dout_arr[1] = dout_1;
    assign dout_arr[2] = dout_2;
    assign vld_g       = vld_vec[grant_reg];
    assign dout_g      = dout_arr[grant_reg];

    assign m_valid = (count_reg != 2'd0);
    assign deq     = m_valid & m_ready;
    assign enq     = inflight_reg;
    // Occupancy as it will stand after this edge; a new read may only be issued
    // if its byte is guaranteed a slot when it lands next cycle.
    assign occ_proj = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, deq};
    assign space    = (occ_proj < 3'd2);

    always_comb begin
        rd = 1'b0;
        case (state_reg)
            HDR:     rd = vld_g & space;
            BODY:    rd = vld_g & (remaining_reg != 7'd0) & space;
            default: rd = 1'b0;
        endcase
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_rd_en
        assign rd_en_vec[gi] = rd & (grant_reg == 2'(gi));
    end
    assign rd_en_0 = rd_en_vec[0];
    assign rd_en_1 = rd_en_vec[1];
    assign rd_en_2 = rd_en_vec[2];

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        pick  = rr_ptr_reg;
        found = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (vld_vec[wrap3({1'b0, rr_ptr_reg} + 3'(k))]) begin
                pick  = wrap3({1'b0, rr_ptr_reg} + 3'(k));
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        rr_ptr_next      = rr_ptr_reg;
        remaining_next   = remaining_reg;
        idle_cnt_next    = idle_cnt_reg;
        timeout_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    grant_next = pick;
                    state_next = HDR;
                end
            end
            HDR: begin
                if (rd) state_next = HDR_WAIT;
            end
            HDR_WAIT: begin
                remaining_next = {1'b0, dout_g[7:2]} + 7'd1;
                idle_cnt_next  = '0;
                state_next     = BODY;
            end
            default: begin
                if (rd) begin
                    remaining_next = remaining_reg - 7'd1;
                    idle_cnt_next  = '0;
                end else if ((remaining_reg != 7'd0) && !vld_g) begin
                    if (idle_cnt_reg == CW'(TIMEOUT - 1)) begin
                        timeout_err_next = 1'b1;
                        state_next       = IDLE;
                        rr_ptr_next      = wrap3({1'b0, grant_reg} + 3'd1);
                        remaining_next   = 7'd0;
                        idle_cnt_next    = '0;
                    end else begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                    end
                end else begin
                    idle_cnt_next = '0;
                end
                if (inflight_reg && inflight_eop_reg) begin
                    state_next    = IDLE;
                    rr_ptr_next   = wrap3({1'b0, grant_reg} + 3'd1);
                    idle_cnt_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            grant_reg        <= 2'd0;
            rr_ptr_reg       <= 2'd0;
            remaining_reg    <= 7'd0;
            idle_cnt_reg     <= '0;
            timeout_err_reg  <= 1'b0;
            inflight_reg     <= 1'b0;
            inflight_sop_reg <= 1'b0;
            inflight_eop_reg <= 1'b0;
            wr_ptr_reg       <= 1'b0;
            rd_ptr_reg       <= 1'b0;
            count_reg        <= 2'd0;
        end else begin
            state_reg        <= state_next;
            grant_reg        <= grant_next;
            rr_ptr_reg       <= rr_ptr_next;
            remaining_reg    <= remaining_next;
            idle_cnt_reg     <= idle_cnt_next;
            timeout_err_reg  <= timeout_err_next;
            inflight_reg     <= rd;
            inflight_sop_reg <= (state_reg == HDR);
            inflight_eop_reg <= (state_reg == BODY) && (remaining_reg == 7'd1);
            if (enq) wr_ptr_reg <= ~wr_ptr_reg;
            if (deq) rd_ptr_reg <= ~rd_ptr_reg;
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Buffer storage needs no reset: every output is gated by m_valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_data[wr_ptr_reg] <= dout_g;
            fifo_port[wr_ptr_reg] <= grant_reg;
            fifo_sop[wr_ptr_reg]  <= inflight_sop_reg;
            fifo_eop[wr_ptr_reg]  <= inflight_eop_reg;
        end
    end

    assign m_data      = m_valid ? fifo_data[rd_ptr_reg] : 8'd0;
    assign m_port      = m_valid ? fifo_port[rd_ptr_reg] : 2'd0;
    assign m_sop       = m_valid & fifo_sop[rd_ptr_reg];
    assign m_eop       = m_valid & fifo_eop[rd_ptr_reg];
    assign timeout_err = timeout_err_reg;
endmodule

// File: tb/tb_router_drain_arb.sv
// Bench for router_drain_arb: queue-backed router FIFO models, packet-level
// round-robin reference model and an output scoreboard.
module tb_router_drain_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] vld_v = 3'b000;
    logic [7:0] dout_v [3] = '{8'h00, 8'h00, 8'h00};
    logic       rd_en_0, rd_en_1, rd_en_2;
    logic [7:0] m_data;
    logic       m_valid, m_sop, m_eop, timeout_err;
    logic       m_ready = 1'b1;
    logic [1:0] m_port;

    always #5 clk = ~clk;

    router_drain_arb #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .vld_out_0(vld_v[0]), .vld_out_1(vld_v[1]), .vld_out_2(vld_v[2]),
        .dout_0(dout_v[0]), .dout_1(dout_v[1]), .dout_2(dout_v[2]),
        .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop), .m_port(m_port),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic [1:0] port;
    } beat_t;

    beat_t      exp_q [$];
    logic [7:0] src_q [3][$];
    logic [7:0] mdl_bytes [3][$];
    int         mdl_len [3][$];
    int         mdl_rr = 0;
    int         sop_ports [$];
    int         checks = 0, failures = 0;
    int         to_cnt = 0, reads = 0, xfers = 0, pkt_bytes = 0;

    // Router FIFO model: read strobe seen this cycle, data presented after the edge.
    always begin : src_driver
        logic [2:0] rdv;
        @(negedge clk);
        rdv = {rd_en_2, rd_en_1, rd_en_0};
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) begin
            if (rdv[p] && src_q[p].size() > 0) dout_v[p] = src_q[p].pop_front();
            vld_v[p] = (src_q[p].size() > 0);
        end
    end

    always @(negedge clk) begin : monitor
        logic [2:0] rdn;
        beat_t      cur, e;
        beat_t      prev_beat;
        logic       hold;
        if (!rst) begin
            reads = 0;
            xfers = 0;
            hold  = 1'b0;
        end else begin
            rdn = {rd_en_2, rd_en_1, rd_en_0};
            cur = {m_data, m_sop, m_eop, m_port};
            if (hold) begin
                checks++;
                if (!m_valid || cur !== prev_beat) begin
                    failures++;
                    $display("FAIL stall_stable got v=%b %h expected v=1 %h", m_valid, cur, prev_beat);
                end
            end
            if (m_valid && m_ready) begin
                xfers++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat_unexpected got d=%02h sop=%b eop=%b port=%0d expected none",
                             m_data, m_sop, m_eop, m_port);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL beat got d=%02h sop=%b eop=%b port=%0d expected d=%02h sop=%b eop=%b port=%0d",
                                 cur.d, cur.sop, cur.eop, cur.port, e.d, e.sop, e.eop, e.port);
                    end
                end
                if (m_sop) begin
                    sop_ports.push_back(int'(m_port));
                    pkt_bytes = 0;
                end
                pkt_bytes++;
                if (m_eop) $display("xfer packet port=%0d bytes=%0d", m_port, pkt_bytes);
            end
            if (rdn != 3'b000) begin
                reads++;
                checks++;
                if ($countones(rdn) > 1 || (rdn & ~vld_v) != 3'b000 || reads - xfers > 2) begin
                    failures++;
                    $display("FAIL rd_en_legal got rd_en=%b vld_out=%b outstanding=%0d expected onehot within vld_out, outstanding<=2",
                             rdn, vld_v, reads - xfers);
                end
            end
            hold      = m_valid && !m_ready;
            prev_beat = cur;
            if (timeout_err) to_cnt++;
        end
    end

    task automatic push_byte(input int p, input logic [7:0] b);
        src_q[p].push_back(b);
        mdl_bytes[p].push_back(b);
    endtask

    task automatic add_packet(input int p, input int len);
        push_byte(p, {6'(len), 2'($urandom_range(0, 3))});
        for (int i = 0; i < len; i++) push_byte(p, 8'($urandom));
        push_byte(p, 8'($urandom));
        mdl_len[p].push_back(len);
    endtask

    // Packet-level reference: whole packets, round-robin from mdl_rr.
    task automatic run_model();
        while (mdl_len[0].size() + mdl_len[1].size() + mdl_len[2].size() > 0) begin
            int g;
            int len;
            logic [7:0] b;
            g = 0;
            for (int k = 2; k >= 0; k--)
                if (mdl_len[(mdl_rr + k) % 3].size() > 0) g = (mdl_rr + k) % 3;
            len = mdl_len[g].pop_front();
            for (int i = 0; i < len + 2; i++) begin
                b = mdl_bytes[g].pop_front();
                exp_q.push_back(beat_t'({b, i == 0, i == len + 1, 2'(g)}));
            end
            mdl_rr = (g + 1) % 3;
        end
    endtask

    task automatic drain(input bit rnd, input int bound);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(posedge clk);
            #1;
            m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        m_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_done got %0d beats pending after %0d cycles expected 0", exp_q.size(), n);
        end
        repeat (3) @(posedge clk);
        checks++;
        if (src_q[0].size() + src_q[1].size() + src_q[2].size() != 0) begin
            failures++;
            $display("FAIL src_empty got %0d/%0d/%0d bytes unread expected 0",
                     src_q[0].size(), src_q[1].size(), src_q[2].size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int p = 0; p < 3; p++) src_q[p].push_back(8'hFF);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({rd_en_2, rd_en_1, rd_en_0} !== 3'b000) begin
                failures++;
                $display("FAIL reset_rd_en got %b expected 000", {rd_en_2, rd_en_1, rd_en_0});
            end
            checks++;
            if ({m_valid, m_data, m_sop, m_eop, m_port, timeout_err} !== 14'd0) begin
                failures++;
                $display("FAIL reset_outputs got v=%b d=%h sop=%b eop=%b port=%0d to=%b expected all 0",
                         m_valid, m_data, m_sop, m_eop, m_port, timeout_err);
            end
        end
        for (int p = 0; p < 3; p++) src_q[p].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        mdl_rr = 0;
    endtask

    task automatic test_contention();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            sop_ports.delete();
            for (int p = 0; p < 3; p++) add_packet(p, 1);
            run_model();
            drain(1'b0, 200);
            checks++;
            if (sop_ports.size() != 3) begin
                failures++;
                $display("FAIL contention_count got %0d packets expected 3", sop_ports.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (sop_ports[i] !== i) begin
                        failures++;
                        $display("FAIL contention_order slot %0d got port %0d expected %0d", i, sop_ports[i], i);
                    end
                end
            end
        end
    endtask

    task automatic test_single();
        int n;
        @(negedge clk);
        push_byte(1, 8'h0D);
        push_byte(1, 8'hA1);
        push_byte(1, 8'hA2);
        push_byte(1, 8'hA3);
        push_byte(1, 8'h0F);
        mdl_len[1].push_back(3);
        run_model();
        @(posedge clk);
        #2;
        n = 0;
        while (!m_valid && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL header_latency got %0d cycles expected 3", n);
        end
        checks++;
        if ({m_data, m_sop, m_eop, m_port} !== {8'h0D, 1'b1, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL header_first got d=%h sop=%b eop=%b port=%0d expected d=0d sop=1 eop=0 port=1",
                     m_data, m_sop, m_eop, m_port);
        end
        drain(1'b0, 200);
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        add_packet($urandom_range(0, 2), 8);
        run_model();
        n = 0;
        while (exp_q.size() > 7 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        m_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (reads - xfers != 2) begin
            failures++;
            $display("FAIL stall_fill got outstanding=%0d expected 2", reads - xfers);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain(1'b0, 200);
    endtask

    task automatic test_timeout();
        int n, base;
        logic [7:0] b;
        @(negedge clk);
        base = to_cnt;
        src_q[2].push_back(8'h15);
        exp_q.push_back(beat_t'({8'h15, 1'b1, 1'b0, 2'd2}));
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            src_q[2].push_back(b);
            exp_q.push_back(beat_t'({b, 1'b0, 1'b0, 2'd2}));
        end
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        // 16 idle cycles follow the last strobe; the poll starts two cycles in.
        checks++;
        if (n != 14) begin
            failures++;
            $display("FAIL timeout_delay got %0d cycles expected 14", n);
        end
        repeat (5) @(posedge clk);
        checks++;
        if (to_cnt != base + 1) begin
            failures++;
            $display("FAIL timeout_pulses got %0d expected 1", to_cnt - base);
        end
        mdl_rr = 0;
        @(negedge clk);
        add_packet(0, $urandom_range(0, 6));
        run_model();
        drain(1'b0, 200);
    endtask

    task automatic test_random();
        int base;
        for (int r = 0; r < 6; r++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++)
                repeat ($urandom_range(0, 2)) add_packet(p, $urandom_range(0, 12));
            run_model();
            base = to_cnt;
            drain(1'b1, 3000);
            checks++;
            if (to_cnt != base) begin
                failures++;
                $display("FAIL random_no_timeout got %0d pulses expected 0", to_cnt - base);
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        @(negedge clk);
        add_packet(0, 8);
        run_model();
        n = 0;
        while (exp_q.size() > 7 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({rd_en_2, rd_en_1, rd_en_0, m_valid, m_data, m_sop, m_eop, m_port, timeout_err} !== 17'd0) begin
            failures++;
            $display("FAIL midreset_outputs got rd_en=%b v=%b d=%h sop=%b eop=%b port=%0d expected all 0",
                     {rd_en_2, rd_en_1, rd_en_0}, m_valid, m_data, m_sop, m_eop, m_port);
        end
        @(posedge clk);
        #3;
        for (int p = 0; p < 3; p++) begin
            src_q[p].delete();
            mdl_bytes[p].delete();
            mdl_len[p].delete();
        end
        exp_q.delete();
        mdl_rr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        add_packet(1, $urandom_range(0, 10));
        run_model();
        drain(1'b0, 200);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_timeout();
        test_random();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish expected finish before 1000000");
        $fatal(1);
    end
endmodule

// File: doc/router_drain_arb.md
ROUTER_DRAIN_ARB -- requirements
Module: router_drain_arb

Interface
REQ-001 Parameter TIMEOUT, default 16, consecutive mid-packet idle cycles before abort.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 vld_out_0 / vld_out_1 / vld_out_2  input  1 each  router output FIFO n non-empty.
REQ-005 dout_0 / dout_1 / dout_2  input  8 each  router output FIFO n read data; valid the cycle after rd_en_n.
REQ-006 rd_en_0 / rd_en_1 / rd_en_2  output  1 each  read strobe to router output FIFO n.
REQ-007 m_data  output  8  merged byte to single downstream sink.
REQ-008 m_valid  output  1  m_data valid; byte transfers when m_valid & m_ready.
REQ-009 m_ready  input  1  sink accepts byte.
REQ-010 m_sop / m_eop  output  1 each  byte is header / parity (last) byte of packet.
REQ-011 m_port  output  2  source port (0..2) of current m_data.
REQ-012 timeout_err  output  1  one-cycle pulse on packet abort.

Function
REQ-013 Packet format SHALL be: header byte (len = header[7:2], header[1:0] ignored), len payload bytes, one parity byte; total len+2 bytes.
REQ-014 Block SHALL drain whole packets from the three router outputs onto one stream, one packet at a time, no interleaving.
REQ-015 FSM states SHALL be IDLE, HDR, HDR_WAIT, BODY.
REQ-016 IDLE: grant first port with vld_out high searching from rr_ptr upward mod 3; none -> stay IDLE.
REQ-017 IDLE->HDR on grant; HDR asserts rd_en_g for one cycle when buffer space exists, then ->HDR_WAIT.
REQ-018 HDR_WAIT: capture dout_g as header, enqueue with sop=1, load remaining = len+1, ->BODY.
REQ-019 BODY: assert rd_en_g when vld_out_g=1, remaining>0 and buffer space; decrement remaining per strobe; byte enqueued the following cycle; eop=1 on the byte read when remaining was 1.
REQ-020 BODY->IDLE when last byte enqueued; rr_ptr <= (g+1) mod 3.
REQ-021 len=0: packet is header+parity only (remaining=1); header SHALL carry sop=1, eop=0.
REQ-022 At most one rd_en high per cycle; rd_en_n never high while vld_out_n=0 or n≠g.
REQ-023 Output buffer SHALL be 2-entry FIFO of {data, sop, eop, port}; rd_en issued only if occupancy + in-flight reads < 2.
REQ-024 Simultaneous enqueue and dequeue SHALL be allowed when full (occupancy stays 2).
REQ-025 Byte order SHALL be preserved; m_data/m_sop/m_eop/m_port SHALL be stable while m_valid=1 and m_ready=0.
REQ-026 Full throughput: with m_ready=1 and vld_out_g=1, one byte per cycle in BODY.
REQ-027 Latency: vld_out_g rising in IDLE -> header on m_valid in 3 cycles (grant, HDR read, HDR_WAIT enqueue).
REQ-028 Timeout: in BODY, TIMEOUT consecutive cycles with remaining>0 and vld_out_g=0 -> timeout_err=1 one cycle, ->IDLE, rr_ptr advanced, no eop generated; already-buffered bytes still drain.
REQ-029 Idle counter SHALL clear on any strobe and on leaving BODY; stall from m_ready=0 SHALL NOT count.

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, rr_ptr 0, remaining 0, buffer empty, rd_en_0..2=0, m_valid=0, m_data=0, m_sop=0, m_eop=0, m_port=0, timeout_err=0.
REQ-031 Reset mid-packet SHALL discard all partial state; after release, next header from any port is accepted normally.

Verification
REQ-032 Reset: rst=0 for 3 cycles with vld_out_0..2=1 -> all outputs 0, no rd_en.
REQ-033 Single packet: port 1 header 0x0D (len 3), payload 0xA1,0xA2,0xA3, parity 0x0F, m_ready=1 -> 5 bytes in order, m_sop on 0x0D, m_eop on 0x0F, m_port=1, header 3 cycles after vld_out_1.
REQ-034 Contention: all three ports hold len-1 packets at once after reset -> packets output port order 0,1,2; repeat -> order 0,1,2 again (rr_ptr=0).
REQ-035 Backpressure: len-8 packet, m_ready=0 for 10 cycles mid-packet -> occupancy ≤2, no rd_en while full, stable outputs, all 10 bytes intact after release.
REQ-036 Timeout: port 2 len 5, vld_out_2 drops after 2 payload bytes for 16 cycles -> single timeout_err pulse, IDLE, next packet on port 0 drained with correct sop/eop.
REQ-037 Mid-packet reset: rst=0 during BODY of port 0 -> outputs 0 same cycle; after release port 1 packet drained correctly.
